// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer.
// Fetches one word per instruction over a req/ack handshake, holds it for a
// single EXEC cycle, then picks the next PC (sequential, branch or jalr).
// Provides halt/resume and a sticky trap (fetch timeout, illegal select,
// misaligned target). Reset is synchronous and active-low.
module pc_fetch_sequencer #(
   parameter int               XLEN            = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR    = '0,
   parameter int               IMEM_ADDR_WIDTH = 8,
   parameter int               MAX_WAIT        = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   input  logic                       imem_ack,
   input  logic [XLEN-1:0]            imem_rdata,
   output logic [XLEN-1:0]            instr,
   output logic                       instr_valid,
   output logic [XLEN-1:0]            pc,
   input  logic [1:0]                 pc_src,
   input  logic                       branch_taken,
   input  logic [XLEN-1:0]            branch_offset,
   input  logic [XLEN-1:0]            jalr_target,
   input  logic                       halt_req,
   input  logic                       resume,
   output logic [2:0]                 state,
   output logic                       trap,
   output logic [1:0]                 trap_cause
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_WAIT  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_TRAP  = 3'd4
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] BIT0_MASK  = ~XLEN'(1);
   localparam logic [7:0]      MAX_WAIT_C = 8'(MAX_WAIT);

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b01;
   localparam logic [1:0] CAUSE_ILL_SRC  = 2'b10;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic [1:0]        cause_q, cause_d;
   logic [XLEN-1:0]   pc_seq;
   logic [XLEN-1:0]   pc_cand;

   // State register: every flop is cleared by the synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         wait_cnt_q <= '0;
         cause_q    <= CAUSE_NONE;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         wait_cnt_q <= wait_cnt_d;
         cause_q    <= cause_d;
      end
   end

   // Next-state logic: fetch handshake, timeout counting and next-PC selection
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      wait_cnt_d = wait_cnt_q;
      cause_d    = cause_q;

      // Arithmetic wraps modulo 2^XLEN; jalr always drops bit 0.
      pc_seq = pc_q + PC_STEP;
      case (pc_src)
         2'b01:   pc_cand = branch_taken ? (pc_q + branch_offset) : pc_seq;
         2'b10:   pc_cand = jalr_target & BIT0_MASK;
         default: pc_cand = pc_seq;
      endcase

      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d    = imem_rdata;
               wait_cnt_d = '0;
               state_d    = ST_EXEC;
            end else begin
               wait_cnt_d = 8'd1;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_ack) begin
               instr_d    = imem_rdata;
               wait_cnt_d = '0;
               state_d    = ST_EXEC;
            end else if (wait_cnt_q == MAX_WAIT_C) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = ST_TRAP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_EXEC: begin
            // A faulting instruction leaves pc pointing at itself.
            if (pc_src == 2'b11) begin
               cause_d = CAUSE_ILL_SRC;
               state_d = ST_TRAP;
            end else if (pc_cand[1:0] != 2'b00) begin
               cause_d = CAUSE_MISALIGN;
               state_d = ST_TRAP;
            end else begin
               pc_d    = pc_cand;
               state_d = halt_req ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_d = ST_FETCH;
            end
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      trap        = 1'b0;
      case (state_q)
         ST_FETCH, ST_WAIT: imem_req    = 1'b1;
         ST_EXEC:           instr_valid = 1'b1;
         ST_TRAP:           trap        = 1'b1;
         default:           ;
      endcase
   end

   assign imem_addr  = pc_q[IMEM_ADDR_WIDTH+1:2];
   assign instr      = instr_q;
   assign pc         = pc_q;
   assign state      = state_q;
   assign trap_cause = cause_q;

endmodule
